z80_bus_bridge: RTL and testbench
=================================

Name: z80_bus_bridge

Overview:
Sits directly downstream of the Z80 CPU wrapper. Consumes the CPU's registered bus strobes, address and write data. Converts each CPU memory or I/O cycle into a single req/ack transaction on a synchronous memory port or I/O port. Stretches the CPU cycle with wait_n until the transaction completes, then presents the read data on the CPU's data-in bus.

Parameters:
INT_VECTOR, 8'hFF, byte returned on interrupt-acknowledge cycles.
TIMEOUT, 255, clk cycles a mem or I/O request may stay un-acked before forced completion; range 1..1023, 10-bit counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
cpu_a  in  16  CPU address
cpu_dout  in  8  CPU write data
cpu_mreq_n  in  1  CPU memory request, active-low
cpu_iorq_n  in  1  CPU I/O request, active-low
cpu_rd_n  in  1  CPU read strobe, active-low
cpu_wr_n  in  1  CPU write strobe, active-low
cpu_m1_n  in  1  CPU opcode fetch / int-ack qualifier, active-low
cpu_rfsh_n  in  1  CPU refresh, active-low
cpu_di  out  8  data to CPU, registered
cpu_wait_n  out  1  wait to CPU, active-low
mem_req  out  1  memory request level, registered
mem_we  out  1  1 = write
mem_addr  out  16  memory address
mem_wdata  out  8  memory write data
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  8  read data, valid with mem_ack
io_req  out  1  I/O request level, registered
io_we  out  1  1 = write
io_addr  out  8  port address (cpu_a[7:0])
io_wdata  out  8  I/O write data
io_ack  in  1  one-cycle completion pulse
io_rdata  in  8  read data, valid with io_ack
timeout_err  out  1  sticky, set on any timeout

Behaviour:
- Reset (async, reset_n low):
  - state IDLE.
  - mem_req, io_req, mem_we, io_we, timeout_err all 0.
  - mem_addr, mem_wdata, io_addr, io_wdata, and the counter all 0.
  - cpu_di = 8'hFF.
  - Reset mid-transaction drops req immediately; a later ack in IDLE is ignored.
- Every clk edge is evaluated; there is no clock enable.
- Start conditions are checked in IDLE only, in priority order:
  - INTACK: cpu_m1_n=0 and cpu_iorq_n=0. cpu_di <= INT_VECTOR, go to DONE. No port activity.
  - MEMCYC: cpu_mreq_n=0, cpu_rfsh_n=1, and (cpu_rd_n=0 or cpu_wr_n=0). Latch the address into mem_addr, latch cpu_dout into mem_wdata, mem_we <= ~cpu_wr_n, mem_req <= 1, go to MEM.
  - IOCYC: cpu_iorq_n=0, cpu_m1_n=1, and (rd or wr low). Same latching onto the io_* outputs, go to IO.
  - Refresh cycles (cpu_rfsh_n=0) are never started.
- MEM / IO states:
  - Hold req and all latched fields stable until ack.
  - On ack: drop req the same edge; for a read, cpu_di <= rdata; for a write, cpu_di is unchanged. Go to DONE.
  - An ack is only honoured while the matching req is 1.
- Timeout:
  - The counter clears on entry to MEM/IO and increments each cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: drop req, cpu_di <= 8'hFF, timeout_err <= 1, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE: stay until cpu_rd_n=1, cpu_wr_n=1 and cpu_iorq_n=1, then return to IDLE. This prevents retriggering within one CPU cycle.
- cpu_wait_n is combinational: 0 when state is MEM or IO, or when state is IDLE and a MEMCYC/IOCYC start condition is true; otherwise 1. INTACK never inserts wait.
- timeout_err clears only on reset.

Test Plan:
- Memory read: strobes A=16'h1234 mreq/rd low; mem_ack with rdata=8'hA5 after 3 cycles -> mem_req high for 3 cycles with mem_addr=16'h1234, mem_we=0; cpu_wait_n low from the strobe cycle until ack; cpu_di=8'hA5 the next cycle; DONE holds until strobes rise.
- Memory write: A=16'hC000, dout=8'h3C, mreq/wr low; ack after 1 cycle -> mem_we=1, mem_wdata=8'h3C; cpu_di unchanged.
- I/O read and int-ack: in/rd port 16'hFE41 with io_rdata=8'h7E -> io_addr=8'h41, cpu_di=8'h7E. Then m1+iorq low -> cpu_di=8'hFF, cpu_wait_n stays 1, no req.
- Refresh and hold: mreq low with rfsh_n low -> no mem_req. Strobes held low through DONE -> exactly one mem_req per CPU cycle.
- Timeout: TIMEOUT=8, no ack -> req drops after 8 cycles, cpu_di=8'hFF, timeout_err=1 and sticky. Ack arriving in the final cycle -> normal completion, timeout_err stays 0.
- Reset mid-MEM: reset_n low while mem_req=1 -> all outputs return to reset values asynchronously; a stray mem_ack afterwards has no effect.

Source files
------------

// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge
//   Turns each Z80 memory or I/O cycle into one req/ack transaction on a
//   synchronous memory port or I/O port. The CPU is held with cpu_wait_n
//   until the transaction finishes, then the read data goes out on cpu_di.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_a, cpu_dout              CPU address / write data
//   cpu_*_n strobes              mreq, iorq, rd, wr, m1, rfsh (active-low)
//   cpu_di, cpu_wait_n           read data to the CPU (registered) and wait
//   mem_req/we/addr/wdata        memory port request (held until ack)
//   mem_ack, mem_rdata           memory completion pulse and read data
//   io_req/we/addr/wdata         I/O port request (held until ack)
//   io_ack, io_rdata             I/O completion pulse and read data
//   timeout_err                  sticky, set when any request times out
module z80_bus_bridge #(
    parameter logic [7:0]  INT_VECTOR = 8'hFF,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_m1_n,
    input  logic        cpu_rfsh_n,
    output logic [7:0]  cpu_di,
    output logic        cpu_wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic        io_ack,
    input  logic [7:0]  io_rdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

    // Last count value before a stalled request is forced to complete.
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cpu_di_q, cpu_di_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        io_req_q, io_req_d;
    logic        io_we_q, io_we_d;
    logic [7:0]  io_addr_q, io_addr_d;
    logic [7:0]  io_wdata_q, io_wdata_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic intack, rw, mem_start, io_start;

    // Start decode. INTACK outranks a memory cycle; an I/O cycle needs m1
    // high, so it can never coincide with INTACK.
    always_comb begin
        intack    = ~cpu_m1_n & ~cpu_iorq_n;
        rw        = ~cpu_rd_n | ~cpu_wr_n;
        mem_start = ~intack & ~cpu_mreq_n & cpu_rfsh_n & rw;
        io_start  = ~intack & ~mem_start & ~cpu_iorq_n & cpu_m1_n & rw;
    end

    always_comb begin
        state_d       = state_q;
        cpu_di_d      = cpu_di_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        io_req_d      = io_req_q;
        io_we_d       = io_we_q;
        io_addr_d     = io_addr_q;
        io_wdata_d    = io_wdata_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (intack) begin
                    cpu_di_d = INT_VECTOR;
                    state_d  = DONE;
                end else if (mem_start) begin
                    mem_addr_d  = cpu_a;
                    mem_wdata_d = cpu_dout;
                    mem_we_d    = ~cpu_wr_n;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = MEM;
                end else if (io_start) begin
                    io_addr_d  = cpu_a[7:0];
                    io_wdata_d = cpu_dout;
                    io_we_d    = ~cpu_wr_n;
                    io_req_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = IO;
                end
            end
            MEM: begin
                // Ack is checked first so it wins over a same-cycle timeout.
                if (mem_ack && mem_req_q) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) cpu_di_d = mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d     = 1'b0;
                    cpu_di_d      = 8'hFF;
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            IO: begin
                if (io_ack && io_req_q) begin
                    io_req_d = 1'b0;
                    if (!io_we_q) cpu_di_d = io_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    io_req_d      = 1'b0;
                    cpu_di_d      = 8'hFF;
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            DONE: begin
                // Wait for the CPU cycle to end so held strobes can't retrigger.
                if (cpu_rd_n && cpu_wr_n && cpu_iorq_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cpu_di_q      <= 8'hFF;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            io_req_q      <= 1'b0;
            io_we_q       <= 1'b0;
            io_addr_q     <= '0;
            io_wdata_q    <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_di_q      <= cpu_di_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            io_req_q      <= io_req_d;
            io_we_q       <= io_we_d;
            io_addr_q     <= io_addr_d;
            io_wdata_q    <= io_wdata_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Wait is asserted combinationally in the strobe cycle itself so the CPU
    // never samples cpu_di before the transaction has finished.
    assign cpu_wait_n  = ~((state_q == MEM) || (state_q == IO) ||
                           ((state_q == IDLE) && (mem_start || io_start)));
    assign cpu_di      = cpu_di_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign io_req      = io_req_q;
    assign io_we       = io_we_q;
    assign io_addr     = io_addr_q;
    assign io_wdata    = io_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed bench for z80_bus_bridge (TIMEOUT = 8). Inputs change on the
// falling edge; outputs are sampled 1 ns later, so registered outputs show
// the result of the previous rising edge and cpu_wait_n reflects the inputs
// just applied.
module tb_z80_bus_bridge;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_mreq_n = 1'b1, cpu_iorq_n = 1'b1, cpu_rd_n = 1'b1;
    logic        cpu_wr_n = 1'b1, cpu_m1_n = 1'b1, cpu_rfsh_n = 1'b1;
    logic [7:0]  cpu_di;
    logic        cpu_wait_n;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata = '0;
    logic        io_req, io_we, io_ack = 1'b0;
    logic [7:0]  io_addr, io_wdata, io_rdata = '0;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    z80_bus_bridge #(.INT_VECTOR(8'hFF), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
        .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n), .cpu_rfsh_n(cpu_rfsh_n),
        .cpu_di(cpu_di), .cpu_wait_n(cpu_wait_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Strobe encodings {mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n}
    localparam logic [5:0] S_IDLE = 6'b111111;
    localparam logic [5:0] S_MRD  = 6'b010111;
    localparam logic [5:0] S_MWR  = 6'b011011;
    localparam logic [5:0] S_IORD = 6'b100111;
    localparam logic [5:0] S_IOWR = 6'b101011;
    localparam logic [5:0] S_INTA = 6'b101101;
    localparam logic [5:0] S_RFSH = 6'b010110;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  dout;
        logic [5:0]  strb;
        logic        mack;
        logic [7:0]  mrd;
        logic        iack;
        logic [7:0]  ird;
        logic [4:0]  e_ctl;   // {wait_n, mem_req, mem_we, io_req, io_we}
        logic [15:0] e_maddr;
        logic [7:0]  e_mwd;
        logic [7:0]  e_ioaddr;
        logic [7:0]  e_iowd;
        logic [7:0]  e_di;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [15:0] a, logic [7:0] dout, logic [5:0] strb,
                                logic mack, logic [7:0] mrd, logic iack, logic [7:0] ird,
                                logic [4:0] ctl, logic [15:0] maddr, logic [7:0] mwd,
                                logic [7:0] ioaddr, logic [7:0] iowd, logic [7:0] di);
        vec_t v;
        v.a = a; v.dout = dout; v.strb = strb; v.mack = mack; v.mrd = mrd;
        v.iack = iack; v.ird = ird; v.e_ctl = ctl; v.e_maddr = maddr;
        v.e_mwd = mwd; v.e_ioaddr = ioaddr; v.e_iowd = iowd; v.e_di = di;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] dout, input logic [5:0] s);
        cpu_a = a; cpu_dout = dout;
        {cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n} = s;
    endtask

    int req_cycles;

    initial begin
        // ---------------- table: read, write, I/O, int-ack, refresh, hold
        vecs.push_back(mk(16'h1234, 8'h00, S_MRD,  0, 8'h00, 0, 8'h00, 5'b00000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'hFF));
        vecs.push_back(mk(16'h1234, 8'h00, S_MRD,  0, 8'h00, 0, 8'h00, 5'b01000, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hFF));
        vecs.push_back(mk(16'h1234, 8'h00, S_MRD,  0, 8'h00, 0, 8'h00, 5'b01000, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hFF));
        vecs.push_back(mk(16'h1234, 8'h00, S_MRD,  1, 8'hA5, 0, 8'h00, 5'b01000, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hFF));
        vecs.push_back(mk(16'h1234, 8'h00, S_MRD,  0, 8'h00, 0, 8'h00, 5'b10000, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'h1234, 8'h00, S_MRD,  0, 8'h00, 0, 8'h00, 5'b10000, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10000, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10000, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'hC000, 8'h3C, S_MWR,  0, 8'h00, 0, 8'h00, 5'b00000, 16'h1234, 8'h00, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'hC000, 8'h3C, S_MWR,  1, 8'h55, 0, 8'h00, 5'b01100, 16'hC000, 8'h3C, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'hFE41, 8'h99, S_IORD, 0, 8'h00, 0, 8'h00, 5'b00100, 16'hC000, 8'h3C, 8'h00, 8'h00, 8'hA5));
        vecs.push_back(mk(16'hFE41, 8'h99, S_IORD, 0, 8'h00, 1, 8'h7E, 5'b00110, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'hA5));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'h7E));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'h7E));
        vecs.push_back(mk(16'h0000, 8'h00, S_INTA, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'h7E));
        vecs.push_back(mk(16'h0000, 8'h00, S_INTA, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'hFF));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'hFF));
        vecs.push_back(mk(16'h5678, 8'h00, S_RFSH, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'hFF));
        vecs.push_back(mk(16'h5678, 8'h00, S_RFSH, 1, 8'h11, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'hFF));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'hFF));
        vecs.push_back(mk(16'h0042, 8'h5A, S_IOWR, 0, 8'h00, 0, 8'h00, 5'b00100, 16'hC000, 8'h3C, 8'h41, 8'h99, 8'hFF));
        vecs.push_back(mk(16'h0042, 8'h5A, S_IOWR, 0, 8'h00, 0, 8'h00, 5'b00111, 16'hC000, 8'h3C, 8'h42, 8'h5A, 8'hFF));
        vecs.push_back(mk(16'h0042, 8'h5A, S_IOWR, 0, 8'h00, 1, 8'h33, 5'b00111, 16'hC000, 8'h3C, 8'h42, 8'h5A, 8'hFF));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10101, 16'hC000, 8'h3C, 8'h42, 8'h5A, 8'hFF));
        vecs.push_back(mk(16'h0000, 8'h00, S_IDLE, 0, 8'h00, 0, 8'h00, 5'b10101, 16'hC000, 8'h3C, 8'h42, 8'h5A, 8'hFF));

        // ---------------- reset values
        @(negedge clk); #1;
        chk("rst_di", cpu_di, 8'hFF);
        chk("rst_ctl", {cpu_wait_n, mem_req, mem_we, io_req, io_we}, 5'b10000);
        chk("rst_fields", {mem_addr, mem_wdata, io_addr, io_wdata}, 40'h0);
        chk("rst_terr", timeout_err, 1'b0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        // ---------------- table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].dout, vecs[i].strb);
            mem_ack = vecs[i].mack; mem_rdata = vecs[i].mrd;
            io_ack = vecs[i].iack;  io_rdata = vecs[i].ird;
            #1;
            chk($sformatf("v%0d_ctl", i), {cpu_wait_n, mem_req, mem_we, io_req, io_we}, vecs[i].e_ctl);
            chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].e_maddr);
            chk($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].e_mwd);
            chk($sformatf("v%0d_ioaddr", i), io_addr, vecs[i].e_ioaddr);
            chk($sformatf("v%0d_iowdata", i), io_wdata, vecs[i].e_iowd);
            chk($sformatf("v%0d_di", i), cpu_di, vecs[i].e_di);
            chk($sformatf("v%0d_terr", i), timeout_err, 1'b0);
        end
        mem_ack = 1'b0; io_ack = 1'b0;

        // ---------------- ack in the last cycle before timeout: ack wins
        @(negedge clk); drive(16'h2222, 8'h00, S_MRD);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            #1; chk($sformatf("lastack_req%0d", i), mem_req, 1'b1);
            @(negedge clk);
        end
        mem_ack = 1'b1; mem_rdata = 8'hC3; #1;
        chk("lastack_req_final", mem_req, 1'b1);
        @(negedge clk); mem_ack = 1'b0; #1;
        chk("lastack_req_drop", mem_req, 1'b0);
        chk("lastack_di", cpu_di, 8'hC3);
        chk("lastack_terr", timeout_err, 1'b0);
        drive(16'h0000, 8'h00, S_IDLE);
        @(negedge clk);

        // ---------------- timeout with no ack
        @(negedge clk); drive(16'h3333, 8'h00, S_MRD);
        req_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (mem_req) req_cycles++;
        end
        chk("to_req_cycles", req_cycles, 8);
        chk("to_req", mem_req, 1'b0);
        chk("to_di", cpu_di, 8'hFF);
        chk("to_terr", timeout_err, 1'b1);
        chk("to_wait", cpu_wait_n, 1'b1);
        drive(16'h0000, 8'h00, S_IDLE);
        @(negedge clk); @(negedge clk);
        // A clean transaction afterwards leaves the error flag set.
        drive(16'h0044, 8'h00, S_IORD);
        @(negedge clk); io_ack = 1'b1; io_rdata = 8'h12;
        @(negedge clk); io_ack = 1'b0; drive(16'h0000, 8'h00, S_IDLE); #1;
        chk("to_sticky_di", cpu_di, 8'h12);
        chk("to_sticky_terr", timeout_err, 1'b1);
        @(negedge clk);

        // ---------------- asynchronous reset mid-MEM, then a stray ack
        @(negedge clk); drive(16'h4444, 8'h77, S_MWR);
        @(negedge clk); #1;
        chk("rmid_req_before", mem_req, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("rmid_req", mem_req, 1'b0);
        chk("rmid_we", mem_we, 1'b0);
        chk("rmid_fields", {mem_addr, mem_wdata, io_addr, io_wdata}, 40'h0);
        chk("rmid_di", cpu_di, 8'hFF);
        chk("rmid_terr", timeout_err, 1'b0);
        drive(16'h0000, 8'h00, S_IDLE);
        @(negedge clk); reset_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'h99;
        @(negedge clk); mem_ack = 1'b0; #1;
        chk("rmid_stray_req", mem_req, 1'b0);
        chk("rmid_stray_di", cpu_di, 8'hFF);
        chk("rmid_stray_wait", cpu_wait_n, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
